// File: rtl/cdc_handshake_sync.sv
// Multi-bit CDC: moves a DATA_WIDTH word from clk_in_a to clk_in_b via a req/ack handshake.
// Define CDC_HS_TWO_PHASE_EN for the toggle (two-phase) protocol; default is four-phase.
module cdc_handshake_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in_b,
    input  logic                  arst_master,
    input  logic                  clk_in_a,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [DATA_WIDTH-1:0] b_data_o,
    output logic                  a_busy_o
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("cdc_handshake_sync: SYNC_STAGES must be >= 2");
        end
    endgenerate

    // ---------------- source domain (clk_in_a) ----------------
    logic                   r_req;
    logic                   r_ack;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_busy;
    logic                   w_ack_s;
    logic                   w_a_ready;
    logic                   w_load;
    logic                   w_req_nxt;

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in_a or posedge arst_master) begin
        if (arst_master) r_ack_sync <= '0;
        else             r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
    end

`ifndef CDC_HS_TWO_PHASE_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} s_state_t;
    s_state_t r_s_state, w_s_state_nxt;

    always_comb begin
        w_s_state_nxt = r_s_state;
        w_req_nxt     = r_req;
        w_load        = 1'b0;
        w_a_ready     = 1'b0;
        case (r_s_state)
            S_IDLE: begin
                w_a_ready = 1'b1;
                if (a_valid_i) begin
                    w_load        = 1'b1;
                    w_req_nxt     = 1'b1;
                    w_s_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack_s) begin
                    w_req_nxt     = 1'b0;
                    w_s_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!w_ack_s) w_s_state_nxt = S_IDLE;
            end
            default: w_s_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in_a or posedge arst_master) begin
        if (arst_master) begin
            r_s_state <= S_IDLE;
            r_req     <= 1'b0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_s_state <= w_s_state_nxt;
            r_req     <= w_req_nxt;
            if (w_load) r_hold <= a_data_i;
            r_busy    <= (w_s_state_nxt != S_IDLE);
        end
    end
`else
    // Ready once the synchronised ack has caught up with the current req phase.
    always_comb begin
        w_a_ready = (r_req == w_ack_s);
        w_load    = a_valid_i && w_a_ready;
        w_req_nxt = r_req ^ w_load;
    end

    always_ff @(posedge clk_in_a or posedge arst_master) begin
        if (arst_master) begin
            r_req  <= 1'b0;
            r_hold <= '0;
            r_busy <= 1'b0;
        end else begin
            r_req  <= w_req_nxt;
            if (w_load) r_hold <= a_data_i;
            r_busy <= (w_req_nxt != r_ack_sync[SYNC_STAGES-2]);
        end
    end
`endif

    assign a_ready_o = w_a_ready;
    assign a_busy_o  = r_busy;

    // ---------------- destination domain (clk_in_b) ----------------
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_b_valid;
    logic [DATA_WIDTH-1:0]  r_b_data;
    logic                   w_req_s;
    logic                   w_capture;
    logic                   w_valid_nxt;
    logic                   w_ack_nxt;

    assign w_req_s = r_req_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in_b or posedge arst_master) begin
        if (arst_master) r_req_sync <= '0;
        else             r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
    end

`ifndef CDC_HS_TWO_PHASE_EN
    typedef enum logic [1:0] {D_IDLE, D_VALID, D_ACK} d_state_t;
    d_state_t r_d_state, w_d_state_nxt;

    always_comb begin
        w_d_state_nxt = r_d_state;
        w_capture     = 1'b0;
        w_valid_nxt   = r_b_valid;
        w_ack_nxt     = r_ack;
        case (r_d_state)
            D_IDLE: begin
                if (w_req_s) begin
                    w_capture     = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_d_state_nxt = D_VALID;
                end
            end
            D_VALID: begin
                if (b_ready_i) begin
                    w_valid_nxt   = 1'b0;
                    w_ack_nxt     = 1'b1;
                    w_d_state_nxt = D_ACK;
                end
            end
            D_ACK: begin
                if (!w_req_s) begin
                    w_ack_nxt     = 1'b0;
                    w_d_state_nxt = D_IDLE;
                end
            end
            default: w_d_state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk_in_b or posedge arst_master) begin
        if (arst_master) begin
            r_d_state <= D_IDLE;
            r_ack     <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
        end else begin
            r_d_state <= w_d_state_nxt;
            r_ack     <= w_ack_nxt;
            r_b_valid <= w_valid_nxt;
            // r_hold is quiescent while req_sync is high, so a plain capture is coherent.
            if (w_capture) r_b_data <= r_hold;
        end
    end
`else
    typedef enum logic {D_IDLE, D_VALID} d_state_t;
    d_state_t r_d_state, w_d_state_nxt;
    logic     r_req_seen;
    logic     w_seen_nxt;

    always_comb begin
        w_d_state_nxt = r_d_state;
        w_capture     = 1'b0;
        w_valid_nxt   = r_b_valid;
        w_ack_nxt     = r_ack;
        w_seen_nxt    = r_req_seen;
        case (r_d_state)
            D_IDLE: begin
                if (w_req_s != r_req_seen) begin
                    w_capture     = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_seen_nxt    = w_req_s;
                    w_d_state_nxt = D_VALID;
                end
            end
            D_VALID: begin
                if (b_ready_i) begin
                    w_valid_nxt   = 1'b0;
                    w_ack_nxt     = ~r_ack;
                    w_d_state_nxt = D_IDLE;
                end
            end
            default: w_d_state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk_in_b or posedge arst_master) begin
        if (arst_master) begin
            r_d_state  <= D_IDLE;
            r_ack      <= 1'b0;
            r_req_seen <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_data   <= '0;
        end else begin
            r_d_state  <= w_d_state_nxt;
            r_ack      <= w_ack_nxt;
            r_req_seen <= w_seen_nxt;
            r_b_valid  <= w_valid_nxt;
            if (w_capture) r_b_data <= r_hold;
        end
    end
`endif

    assign b_valid_o = r_b_valid;
    assign b_data_o  = r_b_data;

endmodule
